// File: rtl/nwc_pkg.sv
// ---------------------------------------------------------------------------
// nwc_pkg
// Shared definitions for the nwc polynomial coefficient store:
//   - ownership FSM state encoding (IDLE / RUN / DRAIN / FIN)
//   - default geometry constants (word width, address width, lanes, latency)
//   - lane-width derivation and read-latency legal-range check
// No ports (package).
// ---------------------------------------------------------------------------
package nwc_pkg;

    localparam int NWC_DATA_W     = 64;
    localparam int NWC_ADDR_W     = 11;
    localparam int NWC_LANES      = 8;
    localparam int NWC_RD_LAT     = 2;

    // Read latency must stay within what the delay line and drain counter support
    localparam int NWC_RD_LAT_MIN = 1;
    localparam int NWC_RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } nwc_state_e;

    function automatic int nwc_lane_w(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

    function automatic bit nwc_rd_lat_legal(input int rd_lat);
        return (rd_lat >= NWC_RD_LAT_MIN) && (rd_lat <= NWC_RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/nwc_poly_mem_if.sv
// ---------------------------------------------------------------------------
// nwc_poly_mem_if
// Host load/unload bus of the polynomial coefficient store.
//   host_valid  request valid          host_ready  request accepted this cycle
//   host_we     1 = write, 0 = read    host_addr   word address
//   host_wdata  full-word write data   host_rdata  read data
//   host_rvalid read data valid
// master = host side, slave = memory side.
// ---------------------------------------------------------------------------
interface nwc_poly_mem_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11
) ();
    logic              host_valid;
    logic              host_ready;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    modport master (
        output host_valid, host_we, host_addr, host_wdata,
        input  host_ready, host_rdata, host_rvalid
    );

    modport slave (
        input  host_valid, host_we, host_addr, host_wdata,
        output host_ready, host_rdata, host_rvalid
    );
endinterface

// File: rtl/nwc_rd_pipe.sv
// ---------------------------------------------------------------------------
// nwc_rd_pipe
// RD_LAT-stage data+valid delay line used to give array reads their
// configured latency. Stages advance only while en is high, so a disabled
// pipe holds its last output.
//   clk, rst_n          clock, async active-low reset (clears all stages)
//   en                  shift enable
//   in_valid, in_data   stage-0 input
//   out_valid, out_data last-stage output
// ---------------------------------------------------------------------------
module nwc_rd_pipe #(
    parameter int DATA_W = 64,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0]             valid_d, valid_q;
    logic [RD_LAT-1:0][DATA_W-1:0] data_d,  data_q;

    // Next-stage values: shift one place when enabled, otherwise hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (en) begin
            valid_d[0] = in_valid;
            data_d[0]  = in_data;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/nwc_poly_mem.sv
// ---------------------------------------------------------------------------
// nwc_poly_mem
// Polynomial coefficient store shared between the host and the
// negacyclic-convolution kernel. An ownership FSM gives the array to the
// kernel on start, lets in-flight kernel reads drain after kernel_done,
// then hands it back to the host.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                host pulse: hand memory to kernel
//   host                 host load/unload bus (nwc_poly_mem_if.slave)
//   addr0/data_out0      kernel read port 0 (RD_LAT pipelined)
//   addr1/data_out1      kernel read port 1 (RD_LAT pipelined)
//   addrw/data_w/wen     kernel write port, per-lane enables
//   kernel_start         one-cycle start pulse to kernel
//   kernel_done          kernel completion pulse
//   busy                 kernel owns memory
//   done                 one-cycle pulse when memory is back with host
// Build option: NWC_MEM_FWD_EN selects write-first read-during-write
// (same-cycle write lanes merged into the read word); read-first otherwise.
// ---------------------------------------------------------------------------
module nwc_poly_mem
    import nwc_pkg::*;
#(
    parameter int DATA_W = NWC_DATA_W,
    parameter int ADDR_W = NWC_ADDR_W,
    parameter int LANES  = NWC_LANES,
    parameter int RD_LAT = NWC_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    nwc_poly_mem_if.slave     host,
    input  logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] data_out0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [DATA_W-1:0] data_out1,
    input  logic [ADDR_W-1:0] addrw,
    input  logic [DATA_W-1:0] data_w,
    input  logic [LANES-1:0]  wen,
    output logic              kernel_start,
    input  logic              kernel_done,
    output logic              busy,
    output logic              done
);

    localparam int LANE_W = nwc_lane_w(DATA_W, LANES);
    localparam int DEPTH  = 2 ** ADDR_W;

    generate
        if (!nwc_rd_lat_legal(RD_LAT) || ((DATA_W % LANES) != 0)) begin : g_param_err
            $error("nwc_poly_mem: RD_LAT out of range or LANES does not divide DATA_W");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [DEPTH];

    nwc_state_e        state_d, state_q;
    logic [1:0]        drain_cnt_d, drain_cnt_q;
    logic              kernel_start_d, kernel_start_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;

    logic              host_acc_s;
    logic              kern_own_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [LANES-1:0]  wr_lane_s;
    logic [DATA_W-1:0] rd0_s, rd1_s, rdh_s;
    logic              k0_valid_unused_s, k1_valid_unused_s;

    // Host is served only in IDLE; every request there is accepted at once
    assign host_acc_s      = host.host_valid && (state_q == ST_IDLE);
    assign host.host_ready = host_acc_s;
    assign kern_own_s      = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // Single write channel: host full-word write in IDLE, kernel lane write while it owns the array
    always_comb begin
        wr_addr_s = '0;
        wr_data_s = '0;
        wr_lane_s = '0;
        if (host_acc_s && host.host_we) begin
            wr_addr_s = host.host_addr;
            wr_data_s = host.host_wdata;
            wr_lane_s = '1;
        end else if (kern_own_s) begin
            wr_addr_s = addrw;
            wr_data_s = data_w;
            wr_lane_s = wen;
        end else begin
            wr_lane_s = '0;
        end
    end

`ifdef NWC_MEM_FWD_EN
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [LANES-1:0]  lanes);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (lanes[i]) begin
                res[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
            end else begin
                res[i*LANE_W +: LANE_W] = old_w[i*LANE_W +: LANE_W];
            end
        end
        return res;
    endfunction

    // Array reads, write-first: enabled lanes of a same-address write are merged in
    always_comb begin
        rd0_s = (addr0 == wr_addr_s) ? lane_merge(mem_q[addr0], wr_data_s, wr_lane_s) : mem_q[addr0];
        rd1_s = (addr1 == wr_addr_s) ? lane_merge(mem_q[addr1], wr_data_s, wr_lane_s) : mem_q[addr1];
        rdh_s = (host.host_addr == wr_addr_s)
                ? lane_merge(mem_q[host.host_addr], wr_data_s, wr_lane_s) : mem_q[host.host_addr];
    end
`else
    // Array reads, read-first: always the pre-write word
    always_comb begin
        rd0_s = mem_q[addr0];
        rd1_s = mem_q[addr1];
        rdh_s = mem_q[host.host_addr];
    end
`endif

    // Lane-masked array update; contents deliberately survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_lane_s[i]) begin
                mem_q[wr_addr_s][i*LANE_W +: LANE_W] <= wr_data_s[i*LANE_W +: LANE_W];
            end
        end
    end

    // Ownership FSM next state; status outputs are derived from the next state so they register cleanly
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (kernel_done) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 2'd0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Hold RD_LAT cycles so the last kernel reads leave the pipes
                if (drain_cnt_q == 2'(RD_LAT - 1)) state_d = ST_FIN;
                else                               drain_cnt_d = drain_cnt_q + 2'd1;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        kernel_start_d = (state_q == ST_IDLE) && (state_d == ST_RUN);
        busy_d         = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d         = (state_d == ST_FIN);
    end

    // FSM state and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            drain_cnt_q    <= 2'd0;
            kernel_start_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            kernel_start_q <= kernel_start_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign kernel_start = kernel_start_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // Kernel pipes run only while the kernel owns the array, so outputs hold in IDLE/FIN
    nwc_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe0 (
        .clk(clk), .rst_n(rst_n), .en(kern_own_s), .in_valid(kern_own_s), .in_data(rd0_s),
        .out_valid(k0_valid_unused_s), .out_data(data_out0)
    );

    nwc_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe1 (
        .clk(clk), .rst_n(rst_n), .en(kern_own_s), .in_valid(kern_own_s), .in_data(rd1_s),
        .out_valid(k1_valid_unused_s), .out_data(data_out1)
    );

    // Host pipe always shifts so a read accepted just before start still returns on time
    nwc_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipeh (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .in_valid(host_acc_s && !host.host_we), .in_data(rdh_s),
        .out_valid(host.host_rvalid), .out_data(host.host_rdata)
    );

endmodule

// File: tb/tb_nwc_poly_mem.sv
// ---------------------------------------------------------------------------
// tb_nwc_poly_mem
// Directed bench for nwc_poly_mem. Stimulus pushes expected read data with
// the cycle it is due into queues; a negedge monitor pops and compares when
// host_rvalid rises (host) or when the due cycle arrives (kernel ports).
// ---------------------------------------------------------------------------
module tb_nwc_poly_mem;
    import nwc_pkg::*;

    localparam int DW = 64;
    localparam int AW = 11;
    localparam int LN = 8;
    localparam int RL = 2;

    localparam logic [DW-1:0] W5  = 64'h0123_4567_89AB_CDEF;
    localparam logic [DW-1:0] W5M = 64'h0123_4567_FFFF_FFFF;
    localparam logic [DW-1:0] W6  = 64'h0000_0000_0000_0011;
    localparam logic [DW-1:0] WAA = 64'h0000_0000_0000_00AA;

`ifdef NWC_MEM_FWD_EN
    localparam logic [DW-1:0] EXP_RDW5 = W5M;
    localparam logic [DW-1:0] EXP_RDW7 = WAA;
`else
    localparam logic [DW-1:0] EXP_RDW5 = W5;
    localparam logic [DW-1:0] EXP_RDW7 = 64'h0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start, kernel_done, kernel_start, busy, done;
    logic [AW-1:0] addr0, addr1, addrw;
    logic [DW-1:0] data_out0, data_out1, data_w;
    logic [LN-1:0] wen;

    always #5 clk = ~clk;

    nwc_poly_mem_if #(.DATA_W(DW), .ADDR_W(AW)) hif ();

    nwc_poly_mem #(.DATA_W(DW), .ADDR_W(AW), .LANES(LN), .RD_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .host(hif),
        .addr0(addr0), .data_out0(data_out0), .addr1(addr1), .data_out1(data_out1),
        .addrw(addrw), .data_w(data_w), .wen(wen),
        .kernel_start(kernel_start), .kernel_done(kernel_done), .busy(busy), .done(done)
    );

    typedef struct { int due; logic [DW-1:0] data; } hexp_t;
    typedef struct { int due; int port; logic [DW-1:0] data; } kexp_t;

    hexp_t hq[$];
    kexp_t kq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_h(input logic [DW-1:0] d);
        hq.push_back('{due: cyc + RL, data: d});
    endtask

    task automatic push_k(input int port, input logic [DW-1:0] d);
        kq.push_back('{due: cyc + RL, port: port, data: d});
    endtask

    task automatic host_req(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        hif.host_valid = v;
        hif.host_we    = we;
        hif.host_addr  = a;
        hif.host_wdata = d;
    endtask

    // Monitor: compare DUT read data against the scoreboard
    always @(negedge clk) begin
        hexp_t he;
        kexp_t ke;
        if (rst_n) begin
            if (hif.host_rvalid) begin
                if (hq.size() == 0) begin
                    chk("host_rvalid_unexpected", 64'd1, 64'd0);
                end else begin
                    he = hq.pop_front();
                    chk("host_rvalid_cycle", 64'(cyc), 64'(he.due));
                    chk("host_rdata", hif.host_rdata, he.data);
                end
            end
            while (kq.size() > 0 && kq[0].due <= cyc) begin
                ke = kq.pop_front();
                if (ke.port == 0) chk("data_out0", data_out0, ke.data);
                else              chk("data_out1", data_out1, ke.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        start = 1'b0; kernel_done = 1'b0;
        addr0 = '0; addr1 = '0; addrw = '0; data_w = '0; wen = '0;
        host_req(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_host_ready",   64'(hif.host_ready),  64'd0);
        chk("rst_host_rvalid",  64'(hif.host_rvalid), 64'd0);
        chk("rst_host_rdata",   hif.host_rdata,       64'd0);
        chk("rst_data_out0",    data_out0,            64'd0);
        chk("rst_data_out1",    data_out1,            64'd0);
        chk("rst_kernel_start", 64'(kernel_start),    64'd0);
        chk("rst_busy",         64'(busy),            64'd0);
        chk("rst_done",         64'(done),            64'd0);
        rst_n = 1'b1;
        tick();

        // Host loads
        addr0 = 11'd5;
        host_req(1'b1, 1'b1, 11'd5, W5);
        #1 chk("idle_ready_wr", 64'(hif.host_ready), 64'd1);
        tick();
        host_req(1'b1, 1'b1, 11'd6, W6);   tick();
        host_req(1'b1, 1'b1, 11'd7, 64'h0); tick();

        // Back-to-back host reads
        host_req(1'b1, 1'b0, 11'd5, '0); push_h(W5); tick();
        host_req(1'b1, 1'b0, 11'd6, '0); push_h(W6); tick();
        host_req(1'b0, 1'b0, '0, '0);
        repeat (4) tick();

        // Kernel write port ignored in IDLE
        addrw = 11'd6; wen = 8'hFF; data_w = 64'hDEAD_BEEF_DEAD_BEEF; tick();
        wen = 8'h00;
        host_req(1'b1, 1'b0, 11'd6, '0); push_h(W6); tick();
        host_req(1'b0, 1'b0, '0, '0);
        repeat (3) tick();
        chk("idle_hold_out0", data_out0, 64'd0);

        // Start together with a host read: read accepted and still returned
        host_req(1'b1, 1'b0, 11'd5, '0); start = 1'b1;
        #1 chk("ready_with_start", 64'(hif.host_ready), 64'd1);
        push_h(W5);
        tick();
        start = 1'b1;                       // ignored while busy
        host_req(1'b1, 1'b0, 11'd6, '0);     // held until the host owns the array again
        #1;
        chk("r1_kernel_start", 64'(kernel_start), 64'd1);
        chk("r1_busy",         64'(busy),         64'd1);
        chk("r1_host_ready",   64'(hif.host_ready), 64'd0);
        addr0 = 11'd5; addr1 = 11'd6; push_k(0, W5); push_k(1, W6);
        tick();
        start = 1'b0;
        #1;
        chk("r2_kernel_start", 64'(kernel_start), 64'd0);
        chk("r2_busy",         64'(busy),         64'd1);
        addrw = 11'd5; wen = 8'h0F; data_w = 64'hFFFF_FFFF_FFFF_FFFF;
        push_k(0, EXP_RDW5); push_k(1, W6);
        tick();
        wen = 8'h00; addr1 = 11'd7;
        push_k(0, W5M); push_k(1, 64'h0);
        tick();
        chk("r4_host_ready", 64'(hif.host_ready), 64'd0);
        addr0 = 11'd7; addr1 = 11'd7; addrw = 11'd7; wen = 8'hFF; data_w = WAA;
        push_k(0, EXP_RDW7); push_k(1, EXP_RDW7);
        tick();
        wen = 8'h00; addr1 = 11'd5; kernel_done = 1'b1;
        push_k(0, WAA); push_k(1, W5M);
        tick();

        // Drain and hand-back
        kernel_done = 1'b0;
        #1;
        chk("d1_busy", 64'(busy), 64'd1);
        chk("d1_done", 64'(done), 64'd0);
        addr0 = 11'd6; push_k(0, W6);
        tick();
        chk("d2_busy",       64'(busy),           64'd1);
        chk("d2_host_ready", 64'(hif.host_ready), 64'd0);
        tick();
        chk("fin_busy",       64'(busy),           64'd0);
        chk("fin_done",       64'(done),           64'd1);
        chk("fin_host_ready", 64'(hif.host_ready), 64'd0);
        tick();
        chk("idle_done",       64'(done),           64'd0);
        chk("idle_host_ready", 64'(hif.host_ready), 64'd1);
        push_h(W6);
        tick();
        host_req(1'b0, 1'b0, '0, '0);
        repeat (3) tick();
        chk("hold_after_run_out0", data_out0, W6);

        // Reset in the middle of RUN
        start = 1'b1; tick();
        start = 1'b0; addr0 = 11'd5;
        #1 chk("rr_busy", 64'(busy), 64'd1);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",        64'(busy),            64'd0);
        chk("mid_rst_kstart",      64'(kernel_start),    64'd0);
        chk("mid_rst_data_out0",   data_out0,            64'd0);
        chk("mid_rst_data_out1",   data_out1,            64'd0);
        chk("mid_rst_host_rvalid", 64'(hif.host_rvalid), 64'd0);
        tick();
        rst_n = 1'b1;
        host_req(1'b1, 1'b0, 11'd5, '0);
        #1 chk("post_rst_host_ready", 64'(hif.host_ready), 64'd1);
        push_h(W5M);
        tick();
        host_req(1'b0, 1'b0, '0, '0);
        repeat (4) tick();

        chk("host_queue_drained",   64'(hq.size()), 64'd0);
        chk("kernel_queue_drained", 64'(kq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
